// File: rtl/mult_tiled_seq.sv
`default_nettype none
// ============================================================================
// mult_tiled_seq : sequential WIDTHxWIDTH multiplier summing LANES exact
//                  2x2-bit tile products per cycle, signed/unsigned, valid/ready.
// Revision       : 1.0
// ============================================================================
module mult_tiled_seq #(
   parameter int WIDTH = 8,
   parameter int LANES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic               in_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_p,
   output logic               busy
);

   localparam int c_half  = WIDTH / 2;
   localparam int c_tiles = c_half * c_half;
   localparam int c_pw    = 2 * WIDTH;
   localparam int c_kw    = $clog2(c_tiles + 1);

   localparam logic [c_kw-1:0] c_h_k     = c_kw'(c_half);
   localparam logic [c_kw-1:0] c_lanes_k = c_kw'(LANES);
   localparam logic [c_kw-1:0] c_last_k  = c_kw'(c_tiles - LANES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic [WIDTH-1:0]  r_ma;
   logic [WIDTH-1:0]  r_mb;
   logic              r_neg;
   logic [c_kw-1:0]   r_k;
   logic [c_pw-1:0]   r_acc;

   logic [WIDTH-1:0]  w_ma;
   logic [WIDTH-1:0]  w_mb;
   logic [c_pw-1:0]   w_batch;
   logic [c_pw-1:0]   w_sum;

   // Two's-complement negation of -2^(WIDTH-1) wraps to 2^(WIDTH-1), which is the
   // correct unsigned magnitude.
   assign w_ma = (in_signed && in_a[WIDTH-1]) ? (~in_a + 1'b1) : in_a;
   assign w_mb = (in_signed && in_b[WIDTH-1]) ? (~in_b + 1'b1) : in_b;

   assign in_ready = (r_state == S_IDLE) && !rst;

   always_comb begin : p_batch
      logic [c_kw-1:0] idx;
      logic [c_kw-1:0] ti;
      logic [c_kw-1:0] tj;
      logic [1:0]      da;
      logic [1:0]      db;
      logic [3:0]      tile;
      w_batch = '0;
      idx     = '0;
      ti      = '0;
      tj      = '0;
      da      = '0;
      db      = '0;
      tile    = '0;
      for (int l = 0; l < LANES; l++) begin
         idx     = r_k + c_kw'(l);
         ti      = idx % c_h_k;
         tj      = idx / c_h_k;
         da      = 2'(r_ma >> (2 * ti));
         db      = 2'(r_mb >> (2 * tj));
         tile    = {2'b00, da} * {2'b00, db};
         w_batch = w_batch + (c_pw'(tile) << (2 * (ti + tj)));
      end
   end

   assign w_sum = r_acc + w_batch;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_ma      <= '0;
         r_mb      <= '0;
         r_neg     <= 1'b0;
         r_k       <= '0;
         r_acc     <= '0;
         out_valid <= 1'b0;
         out_p     <= '0;
         busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_ma    <= w_ma;
                  r_mb    <= w_mb;
                  r_neg   <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                  r_acc   <= '0;
                  r_k     <= '0;
                  busy    <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (r_k == c_last_k) begin
                  out_p     <= r_neg ? (~w_sum + 1'b1) : w_sum;
                  out_valid <= 1'b1;
                  r_state   <= S_DONE;
               end else begin
                  r_acc <= w_sum;
                  r_k   <= r_k + c_lanes_k;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mult_tiled_seq.sv
`default_nettype none
// ============================================================================
// tb_mult_tiled_seq : self-checking bench for mult_tiled_seq (8-bit/2-lane,
//                     4-bit/1-lane and 4-bit/4-lane instances).
// Revision          : 1.0
// ============================================================================
module tb_mult_tiled_seq;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        in_valid, in_ready, in_signed, out_valid, out_ready, busy;
   logic [7:0]  in_a, in_b;
   logic [15:0] out_p;

   logic        v4 [2];
   logic        r4 [2];
   logic        s4 [2];
   logic        ov4 [2];
   logic        or4 [2];
   logic        b4 [2];
   logic [3:0]  a4 [2];
   logic [3:0]  bb4 [2];
   logic [7:0]  p4 [2];

   mult_tiled_seq #(.WIDTH(8), .LANES(2)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .out_valid(out_valid),
      .out_ready(out_ready), .out_p(out_p), .busy(busy)
   );

   mult_tiled_seq #(.WIDTH(4), .LANES(1)) u_dut4_l1 (
      .clk(clk), .rst(rst), .in_valid(v4[0]), .in_ready(r4[0]),
      .in_a(a4[0]), .in_b(bb4[0]), .in_signed(s4[0]), .out_valid(ov4[0]),
      .out_ready(or4[0]), .out_p(p4[0]), .busy(b4[0])
   );

   mult_tiled_seq #(.WIDTH(4), .LANES(4)) u_dut4_l4 (
      .clk(clk), .rst(rst), .in_valid(v4[1]), .in_ready(r4[1]),
      .in_a(a4[1]), .in_b(bb4[1]), .in_signed(s4[1]), .out_valid(ov4[1]),
      .out_ready(or4[1]), .out_p(p4[1]), .busy(b4[1])
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference: true integer product of the (optionally sign-extended) operands, mod 2^(2w).
   function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a,
                                           input logic [31:0] b, input bit s);
      longint sa, sb, p;
      sa = longint'(a);
      sb = longint'(b);
      if (s && a[w-1]) sa = sa - (longint'(1) << w);
      if (s && b[w-1]) sb = sb - (longint'(1) << w);
      p = sa * sb;
      return 64'(p & ((longint'(1) << (2 * w)) - 1));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept8(input logic [7:0] a, input logic [7:0] b, input bit s);
      int n = 0;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      in_a      = a;
      in_b      = b;
      in_signed = s;
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
   endtask

   task automatic wait8(input logic [15:0] exp, input string nm);
      int lat = 0;
      bit bad = 1'b0;
      while (!out_valid && lat < 40) begin
         if (!busy || in_ready) bad = 1'b1;
         tick();
         lat++;
      end
      check({nm, " latency"}, 64'(lat), 64'd8);
      check({nm, " busy/in_ready during run"}, 64'(bad), 64'd0);
      check({nm, " product"}, 64'(out_p), 64'(exp));
   endtask

   task automatic handshake8(input string nm);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({nm, " out_valid after handshake"}, 64'(out_valid), 64'd0);
      check({nm, " in_ready after handshake"}, 64'(in_ready), 64'd1);
   endtask

   task automatic op4(input int d, input logic [3:0] a, input logic [3:0] b, input bit s);
      int lat = 0;
      int n = 0;
      logic [63:0] exp;
      exp = ref_mul(4, 32'(a), 32'(b), s);
      while (!r4[d] && n < 50) begin
         tick();
         n++;
      end
      a4[d]  = a;
      bb4[d] = b;
      s4[d]  = s;
      v4[d]  = 1'b1;
      tick();
      v4[d]  = 1'b0;
      while (!ov4[d] && lat < 50) begin
         tick();
         lat++;
      end
      check($sformatf("w4 lanes%0d latency", (d == 0) ? 1 : 4), 64'(lat),
            (d == 0) ? 64'd4 : 64'd1);
      check($sformatf("w4 lanes%0d s%0d %0d*%0d", (d == 0) ? 1 : 4, s, a, b),
            64'(p4[d]), exp);
      or4[d] = 1'b1;
      tick();
      or4[d] = 1'b0;
   endtask

   task automatic stream8();
      logic [15:0] expq[$];
      int cyc  = 0;
      int last = -1;
      int nacc = 0;
      int nres = 0;
      bit rdy_before;
      out_ready = 1'b1;
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      in_signed = 1'($urandom);
      in_valid  = 1'b1;
      while (nres < 20 && cyc < 1000) begin
         rdy_before = in_ready;
         tick();
         cyc++;
         if (out_valid) begin
            if (expq.size() == 0) begin
               check("stream spurious result", 64'(out_valid), 64'd0);
            end else begin
               check($sformatf("stream result %0d", nres), 64'(out_p), 64'(expq.pop_front()));
               nres++;
            end
         end
         if (rdy_before && in_valid) begin
            expq.push_back(16'(ref_mul(8, 32'(in_a), 32'(in_b), in_signed)));
            if (last >= 0) check("stream acceptance spacing", 64'(cyc - last), 64'd10);
            last = cyc;
            nacc++;
            if (nacc < 20) begin
               in_a      = 8'($urandom);
               in_b      = 8'($urandom);
               in_signed = 1'($urandom);
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      check("stream result count", 64'(nres), 64'd20);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tick();
   endtask

   typedef struct packed {
      logic [7:0]  a;
      logic [7:0]  b;
      logic        s;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs [8];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit bad;
      vecs[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
      vecs[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};
      vecs[2] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
      vecs[3] = '{8'h07, 8'hFD, 1'b1, 16'hFFEB};
      vecs[4] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
      vecs[5] = '{8'h00, 8'hFB, 1'b1, 16'h0000};
      vecs[6] = '{8'hFF, 8'h01, 1'b0, 16'h00FF};
      vecs[7] = '{8'h80, 8'h80, 1'b0, 16'h4000};

      in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; out_ready = 1'b0;
      for (int d = 0; d < 2; d++) begin
         v4[d] = 1'b0; a4[d] = '0; bb4[d] = '0; s4[d] = 1'b0; or4[d] = 1'b0;
      end

      rst = 1'b1;
      tick();
      tick();
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset out_p", 64'(out_p), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      check("reset in_ready", 64'(in_ready), 64'd0);
      rst = 1'b0;
      #1;
      check("in_ready after reset release", 64'(in_ready), 64'd1);
      tick();

      for (int i = 0; i < 8; i++) begin
         accept8(vecs[i].a, vecs[i].b, vecs[i].s);
         wait8(vecs[i].exp, $sformatf("vec%0d", i));
         handshake8($sformatf("vec%0d", i));
      end

      // Backpressure with a new operand pair offered while the result is held.
      accept8(8'd5, 8'd6, 1'b0);
      wait8(16'h001E, "bp first");
      in_a = 8'd3; in_b = 8'd4; in_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (out_p !== 16'h001E || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1)
            bad = 1'b1;
      end
      check("bp hold stable", 64'(bad), 64'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp in not taken on out handshake", 64'(in_ready), 64'd1);
      check("bp out_valid dropped", 64'(out_valid), 64'd0);
      tick();
      in_valid = 1'b0;
      check("bp 3x4 accepted", 64'(busy), 64'd1);
      wait8(16'h000C, "bp 3x4");
      handshake8("bp 3x4");

      // Reset in the middle of a run.
      accept8(8'd200, 8'd100, 1'b0);
      tick(); tick(); tick();
      rst = 1'b1;
      #1;
      check("mid-reset out_valid", 64'(out_valid), 64'd0);
      check("mid-reset out_p", 64'(out_p), 64'd0);
      check("mid-reset busy", 64'(busy), 64'd0);
      check("mid-reset in_ready", 64'(in_ready), 64'd0);
      tick();
      check("in_ready while rst held", 64'(in_ready), 64'd0);
      rst = 1'b0;
      #1;
      check("in_ready after mid-reset release", 64'(in_ready), 64'd1);
      bad = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (out_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      end
      check("no result for discarded op", 64'(bad), 64'd0);
      accept8(8'd10, 8'd10, 1'b0);
      wait8(16'h0064, "post-reset 10x10");
      handshake8("post-reset 10x10");

      stream8();

      for (int d = 0; d < 2; d++)
         for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
               for (int b = 0; b < 16; b++)
                  op4(d, 4'(a), 4'(b), 1'(s));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
